// File: rtl/bounce_gen_if.sv
// Push-button emulator bus: the start request plus the emulated pad level, the
// ideal settled level and the status flags.
interface bounce_gen_if;
    logic start;
    logic busy;
    logic done;
    logic pad_out;
    logic settled;

    // Requester side: raises start, watches the pad and status.
    modport master (
        output start,
        input  busy,
        input  done,
        input  pad_out,
        input  settled
    );

    // Generator side.
    modport slave (
        input  start,
        output busy,
        output done,
        output pad_out,
        output settled
    );
endinterface

// File: rtl/bounce_gen.sv
// bounce_gen: button-bounce emulator. On start it drives pad_out through a press
// bounce burst, a clean hold (settled=1) and a release bounce burst, then pulses
// done. Optional macro BOUNCE_GEN_LFSR_EN makes glitch segment lengths
// pseudo-random (1..2^GLITCH_LOG2) from a 16-bit Galois LFSR; otherwise every
// segment lasts exactly 2^GLITCH_LOG2 cycles.
module bounce_gen #(
    parameter int unsigned BOUNCE_EVENTS = 3,
    parameter int unsigned GLITCH_LOG2   = 3,
    parameter int unsigned HOLD_CYCLES   = 200,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input logic        clk,
    input logic        rst,
    bounce_gen_if.slave bus_io
);

    localparam int unsigned SegW         = GLITCH_LOG2 + 1;
    localparam logic [SegW-1:0] SegFixed = SegW'((1 << GLITCH_LOG2) - 1);
    localparam logic [4:0] LastEvt       = 5'(2 * BOUNCE_EVENTS - 1);
    localparam logic [15:0] HoldLoad     = 16'(HOLD_CYCLES - 1);

    // Parameter range checks at elaboration time.
    if (BOUNCE_EVENTS < 1 || BOUNCE_EVENTS > 15) begin : g_bad_events
        $error("bounce_gen: BOUNCE_EVENTS out of range 1..15");
    end
    if (GLITCH_LOG2 < 1 || GLITCH_LOG2 > 8) begin : g_bad_glitch
        $error("bounce_gen: GLITCH_LOG2 out of range 1..8");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
        $error("bounce_gen: HOLD_CYCLES out of range 1..65535");
    end

    typedef enum logic [2:0] {
        StIdle,
        StPress,
        StHold,
        StRelease,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [SegW-1:0] seg_q, seg_d;
    logic [4:0]      evt_q, evt_d;
    logic [15:0]     hold_q, hold_d;
    logic            pad_q, pad_d;
    logic            settled_q, settled_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            seg_load;     // a new glitch segment starts at this edge
    logic [SegW-1:0] seg_load_val; // segment length minus one

`ifdef BOUNCE_GEN_LFSR_EN
    localparam logic [15:0] LfsrMask = 16'hB400;
    localparam logic [15:0] LfsrInit = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic [15:0] lfsr_q, lfsr_d, lfsr_step;

    // LFSR steps only when a segment is loaded, so runs from reset repeat exactly.
    always_comb begin
        lfsr_step    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
        seg_load_val = {1'b0, lfsr_step[GLITCH_LOG2-1:0]};
        lfsr_d       = seg_load ? lfsr_step : lfsr_q;
    end

    // LFSR register.
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= LfsrInit;
        else     lfsr_q <= lfsr_d;
    end
`else
    // Fixed segment length of 2^GLITCH_LOG2 cycles.
    always_comb seg_load_val = SegFixed;
`endif

    // Next-state logic for the sequencer and its counters.
    always_comb begin
        state_d  = state_q;
        seg_d    = seg_q;
        evt_d    = evt_q;
        hold_d   = hold_q;
        seg_load = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    state_d  = StPress;
                    evt_d    = 5'd0;
                    seg_load = 1'b1;
                end
            end
            StPress, StRelease: begin
                if (seg_q != '0) begin
                    seg_d = seg_q - SegW'(1);
                end else if (evt_q == LastEvt) begin
                    if (state_q == StPress) begin
                        state_d = StHold;
                        hold_d  = HoldLoad;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    evt_d    = evt_q + 5'd1;
                    seg_load = 1'b1;
                end
            end
            StHold: begin
                if (hold_q == 16'd0) begin
                    state_d  = StRelease;
                    evt_d    = 5'd0;
                    seg_load = 1'b1;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (seg_load) seg_d = seg_load_val;
    end

    // Outputs are precomputed from the next state so they come straight from flops.
    always_comb begin
        pad_d     = 1'b0;
        settled_d = 1'b0;
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
        case (state_d)
            StPress:   pad_d = ~evt_d[0];
            StHold: begin
                pad_d     = 1'b1;
                settled_d = 1'b1;
            end
            StRelease: pad_d = evt_d[0];
            default:   pad_d = 1'b0;
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            seg_q     <= '0;
            evt_q     <= 5'd0;
            hold_q    <= 16'd0;
            pad_q     <= 1'b0;
            settled_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            seg_q     <= seg_d;
            evt_q     <= evt_d;
            hold_q    <= hold_d;
            pad_q     <= pad_d;
            settled_q <= settled_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus_io.pad_out = pad_q;
    assign bus_io.settled = settled_q;
    assign bus_io.busy    = busy_q;
    assign bus_io.done    = done_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Self-checking bench for bounce_gen. Each accepted start pushes the expected
// per-cycle {pad_out, settled, busy, done} waveform into a scoreboard queue;
// every cycle one entry is popped (idle when empty) and compared to the DUT.
module tb_bounce_gen;

    localparam int unsigned BE   = 2;
    localparam int unsigned G    = 2;
    localparam int unsigned H    = 10;
    localparam logic [15:0] Seed = 16'hACE1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bounce_gen_if bus ();

    bounce_gen #(
        .BOUNCE_EVENTS (BE),
        .GLITCH_LOG2   (G),
        .HOLD_CYCLES   (H),
        .LFSR_SEED     (Seed)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    typedef struct packed {
        logic pad;
        logic settled;
        logic busy;
        logic done;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks   = 0;
    int   n_fails    = 0;
    int   cyc        = 0;
    int   busy_seen  = 0;
    int   done_seen  = 0;
    int   seq_pushed = 0;
    logic last_busy  = 1'b0;
`ifdef BOUNCE_GEN_LFSR_EN
    logic [15:0] m_lfsr = Seed;
`endif

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s cycle %0d: observed pad/set/busy/done=%b expected %b",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_len(output int len);
`ifdef BOUNCE_GEN_LFSR_EN
        m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        len    = 1 + int'(m_lfsr[G-1:0]);
`else
        len = 1 << G;
`endif
    endtask

    // Expected waveform of one complete press/hold/release/done sequence.
    task automatic push_sequence();
        int   len;
        logic lvl;
        for (int k = 0; k < 2 * int'(BE); k++) begin
            next_len(len);
            lvl = (k % 2 == 0);
            repeat (len) sb_q.push_back({lvl, 1'b0, 1'b1, 1'b0});
        end
        repeat (H) sb_q.push_back(4'b1110);
        for (int k = 0; k < 2 * int'(BE); k++) begin
            next_len(len);
            lvl = (k % 2 == 1);
            repeat (len) sb_q.push_back({lvl, 1'b0, 1'b1, 1'b0});
        end
        sb_q.push_back(4'b0011);
    endtask

    // One clock: drive inputs, update the model at the edge, compare at the negedge.
    task automatic step(input logic s, input logic r, input string tag);
        exp_t e;
        bus.start = s;
        rst       = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            sb_q.delete();
            last_busy = 1'b0;
`ifdef BOUNCE_GEN_LFSR_EN
            m_lfsr = Seed;
`endif
        end else if (s && !last_busy) begin
            push_sequence();
            seq_pushed++;
        end
        @(negedge clk);
        e = (sb_q.size() > 0) ? sb_q.pop_front() : exp_t'(4'b0000);
        last_busy = e.busy;
        check(tag, {bus.pad_out, bus.settled, bus.busy, bus.done}, e);
        busy_seen += int'(bus.busy);
        done_seen += int'(bus.done);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb_q.size() > 0 || last_busy) && n < 500) begin
            step(1'b0, 1'b0, tag);
            n++;
        end
        check_int({tag, "_drain_bound"}, int'(sb_q.size() > 0 || last_busy), 0);
    endtask

    initial begin
        // Reset state.
        repeat (3) step(1'b0, 1'b1, "reset");
        repeat (2) step(1'b0, 1'b0, "idle");

        // Single start pulse.
        busy_seen = 0;
        done_seen = 0;
        step(1'b1, 1'b0, "s1_start");
        drain("s1");
        repeat (2) step(1'b0, 1'b0, "s1_idle");
        check_int("s1_done_pulses", done_seen, 1);
`ifndef BOUNCE_GEN_LFSR_EN
        check_int("s1_busy_cycles", busy_seen, 43);
`endif

        // Extra start pulses while busy are ignored.
        done_seen = 0;
        step(1'b1, 1'b0, "s2_start");
        repeat (4) step(1'b0, 1'b0, "s2_run");
        step(1'b1, 1'b0, "s2_ignored_a");
        repeat (19) step(1'b0, 1'b0, "s2_run");
        step(1'b1, 1'b0, "s2_ignored_b");
        drain("s2");
        step(1'b0, 1'b0, "s2_idle");
        check_int("s2_done_pulses", done_seen, 1);

        // Reset mid-sequence aborts without a done pulse, then a full replay.
        done_seen = 0;
        step(1'b1, 1'b0, "s3_start");
        repeat (19) step(1'b0, 1'b0, "s3_run");
        step(1'b0, 1'b1, "s3_abort");
        check_int("s3_no_done_after_abort", done_seen, 0);
        repeat (3) step(1'b0, 1'b0, "s3_idle");
        step(1'b1, 1'b0, "s3_restart");
        drain("s3");
        check_int("s3_done_pulses", done_seen, 1);

        // start held high: back-to-back sequences with one idle cycle between.
        done_seen  = 0;
        seq_pushed = 0;
        for (int n = 0; n < 1000 && seq_pushed < 3; n++) step(1'b1, 1'b0, "s4_held");
        drain("s4");
        check_int("s4_done_pulses", done_seen, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
